cfrag_cfg_loader: RTL and testbench

Serial configuration sequencer for a chain of logic cells. Each cell holds 8 input-inversion select bits (TAS1, TAS2, TBS1, TBS2, BAS1, BAS2, BBS1, BBS2). The block takes per-cell configuration words from a host over a valid/ready port into a shadow register file. On a commit pulse it shifts the whole image serially into the cell chain, then pulses a latch so all cells switch together. It also keeps a mirror of the active configuration for readback.

---
 rtl/cfrag_cfg_loader.sv | 103 ++++++++++
 tb/tb_cfrag_cfg_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cfrag_cfg_loader.sv
// Configuration sequencer: host writes per-cell words into a shadow file, a commit
// shifts the image serially into the cell chain and latches it, mirroring it on cfg_bits.
`timescale 1ns/1ps
module cfrag_cfg_loader #(
  parameter int NCELLS = 4,
  parameter int ADDR_W = 2
) (
  input  logic                  QCK,
  input  logic                  QRT,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [7:0]            wr_data,
  output logic                  wr_err,
  input  logic                  commit,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_shift,
  output logic                  cfg_sdo,
  output logic                  cfg_latch,
  output logic [8*NCELLS-1:0]   cfg_bits
);

  localparam int unsigned NBITS = 8 * NCELLS;
  localparam int unsigned CNT_W = $clog2(NBITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t             state_q, state_d;
  logic [NBITS-1:0]   shadow, image, sreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               wr_fire, addr_ok;

  assign wr_ready = (state_q == IDLE) && !QRT;
  assign wr_fire  = wr_valid && wr_ready;
  assign addr_ok  = 32'(wr_addr) < NCELLS;

  // Shadow with this cycle's accepted write applied; also forwards a write
  // that coincides with commit into the shift-register load.
  always_comb begin
    image = shadow;
    for (int unsigned i = 0; i < NCELLS; i++) begin
      if (wr_fire && wr_addr == ADDR_W'(i))
        image[8*i +: 8] = wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit) state_d = SHIFT;
      SHIFT:   if (bit_cnt == LAST) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge QCK) begin
    if (QRT) begin
      state_q   <= IDLE;
      shadow    <= '0;
      sreg      <= '0;
      bit_cnt   <= '0;
      cfg_bits  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_shift <= 1'b0;
      cfg_latch <= 1'b0;
      cfg_sdo   <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow    <= image;
      wr_err    <= wr_fire && !addr_ok;
      done      <= (state_q == LATCH);
      busy      <= (state_d != IDLE);
      cfg_shift <= (state_d == SHIFT);
      cfg_latch <= (state_d == LATCH);
      cfg_sdo   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (commit) begin
            sreg    <= image;
            bit_cnt <= '0;
            cfg_sdo <= image[NBITS-1];
          end
        end
        SHIFT: begin
          // cfg_sdo is registered, so it presents the bit the shift is about to expose
          sreg <= sreg << 1;
          if (bit_cnt != LAST) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            cfg_sdo <= sreg[NBITS-2];
          end
        end
        LATCH:   cfg_bits <= shadow;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfrag_cfg_loader.sv
// Directed bench for cfrag_cfg_loader (NCELLS=4, ADDR_W=3): table of chain loads
// plus hand sequences for simultaneous write/commit, busy pokes, mid-shift reset and bad addresses.
`timescale 1ns/1ps
module tb_cfrag_cfg_loader;

  logic        QCK = 1'b0;
  logic        QRT = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_err;
  logic        commit = 1'b0;
  logic        busy, done, cfg_shift, cfg_sdo, cfg_latch;
  logic [31:0] cfg_bits;

  int ncmp = 0;
  int nfail = 0;

  cfrag_cfg_loader #(.NCELLS(4), .ADDR_W(3)) dut (
    .QCK(QCK), .QRT(QRT), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err), .commit(commit),
    .busy(busy), .done(done), .cfg_shift(cfg_shift), .cfg_sdo(cfg_sdo),
    .cfg_latch(cfg_latch), .cfg_bits(cfg_bits)
  );

  always #5 QCK = ~QCK;

  typedef struct {
    string       name;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] exp;
  } load_vec_t;

  task automatic step();
    @(posedge QCK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write_cell(input logic [2:0] addr, input logic [7:0] data);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    QRT = 1'b1;
    #1;
    chk("ready_in_reset", {31'b0, wr_ready}, 32'd0);
    step();
    QRT = 1'b0;
    #1;
    chk("reset_outs", {26'b0, busy, done, cfg_shift, cfg_sdo, cfg_latch, wr_err}, 32'd0);
    chk("reset_bits", cfg_bits, 32'd0);
    chk("ready_after_reset", {31'b0, wr_ready}, 32'd1);
  endtask

  // Commits and observes cycles 1..34 after the commit edge.
  task automatic do_load(input string tag, input logic [31:0] exp, input bit busy_poke,
                         input bit sim_wr, input logic [2:0] sim_addr, input logic [7:0] sim_data);
    int nsh = 0, first = 0, last = 0, nlatch = 0, latch_c = 0, ndone = 0, done_c = 0, nbusy = 0;
    logic [31:0] stream = '0;
    logic [31:0] bits_d = '0;
    logic        rdy_d = 1'b0;
    logic        poke_rdy = 1'b1;
    commit = 1'b1;
    if (sim_wr) begin
      wr_valid = 1'b1;
      wr_addr  = sim_addr;
      wr_data  = sim_data;
    end
    step();
    commit   = 1'b0;
    wr_valid = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (cfg_shift) begin
        nsh++;
        if (first == 0) first = c;
        last = c;
        stream = {stream[30:0], cfg_sdo};
      end
      if (cfg_latch) begin nlatch++; latch_c = c; end
      if (busy) nbusy++;
      if (done) begin ndone++; done_c = c; bits_d = cfg_bits; rdy_d = wr_ready; end
      if (busy_poke && c == 5) begin
        commit = 1'b1; wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 8'h77;
        poke_rdy = wr_ready;
      end else if (busy_poke && c == 6) begin
        commit = 1'b0; wr_valid = 1'b0;
      end
      step();
    end
    chk({tag, " shift_count"}, nsh, 32);
    chk({tag, " shift_first"}, first, 1);
    chk({tag, " shift_last"}, last, 32);
    chk({tag, " latch_count"}, nlatch, 1);
    chk({tag, " latch_cycle"}, latch_c, 33);
    chk({tag, " busy_cycles"}, nbusy, 33);
    chk({tag, " done_count"}, ndone, 1);
    chk({tag, " done_cycle"}, done_c, 34);
    chk({tag, " sdo_stream"}, stream, exp);
    chk({tag, " cfg_bits"}, bits_d, exp);
    chk({tag, " ready_at_done"}, {31'b0, rdy_d}, 32'd1);
    chk({tag, " idle_after"}, {30'b0, busy, done}, 32'd0);
    if (busy_poke) chk({tag, " ready_while_busy"}, {31'b0, poke_rdy}, 32'd0);
  endtask

  initial begin
    load_vec_t vecs[3];
    int nl;
    vecs[0] = '{"corner_bits", 4'b1001, 32'h8000_0001, 32'h8000_0001};
    vecs[1] = '{"mixed",       4'b1111, 32'h00FF_3CA5, 32'h00FF_3CA5};
    vecs[2] = '{"reload",      4'b0000, 32'h0000_0000, 32'h00FF_3CA5};

    step();
    do_reset();

    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (vecs[i].wmask[c]) write_cell(3'(c), vecs[i].wdata[8*c +: 8]);
      end
      do_load(vecs[i].name, vecs[i].exp, 1'b0, 1'b0, 3'd0, 8'h00);
    end

    // write in the same cycle as commit is forwarded into the load
    do_reset();
    do_load("sim_write", 32'h005A_0000, 1'b0, 1'b1, 3'd2, 8'h5A);

    // commit and write while busy are ignored; a later commit reloads the same image
    do_load("busy_poke", 32'h005A_0000, 1'b1, 1'b0, 3'd0, 8'h00);
    do_load("after_poke", 32'h005A_0000, 1'b0, 1'b0, 3'd0, 8'h00);

    // reset at shift cycle 10
    commit = 1'b1;
    step();
    commit = 1'b0;
    for (int c = 1; c < 10; c++) step();
    chk("midshift_active", {31'b0, cfg_shift}, 32'd1);
    QRT = 1'b1;
    #1;
    chk("midshift_ready_in_reset", {31'b0, wr_ready}, 32'd0);
    step();
    QRT = 1'b0;
    #1;
    chk("midshift_outs", {27'b0, busy, done, cfg_shift, cfg_latch, wr_err}, 32'd0);
    chk("midshift_bits", cfg_bits, 32'd0);
    chk("midshift_ready_after", {31'b0, wr_ready}, 32'd1);
    nl = 0;
    for (int c = 0; c < 30; c++) begin
      if (cfg_latch || cfg_shift) nl++;
      step();
    end
    chk("midshift_no_latch", nl, 0);
    do_load("post_reset", 32'h0000_0000, 1'b0, 1'b0, 3'd0, 8'h00);

    // out-of-range addresses: back-to-back bad writes, one pulse each
    write_cell(3'd0, 8'h00);
    chk("good_write_no_err", {31'b0, wr_err}, 32'd0);
    wr_valid = 1'b1; wr_addr = 3'd4; wr_data = 8'hEE;
    step();
    chk("err_addr4", {31'b0, wr_err}, 32'd1);
    wr_addr = 3'd6; wr_data = 8'hDD;
    step();
    wr_valid = 1'b0;
    chk("err_addr6", {31'b0, wr_err}, 32'd1);
    step();
    chk("err_cleared", {31'b0, wr_err}, 32'd0);
    do_load("after_err", 32'h0000_0000, 1'b0, 1'b0, 3'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
